issue_select4: RTL and testbench

ISSUE_SELECT4 -- requirements
Module: issue_select4

---
 rtl/issue_select4.sv | 142 ++++++++++++++
 tb/tb_issue_select4.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_select4.sv
// issue_select4: four-entry issue queue selector.
//
// Holds per-entry occupancy (valid_q) and operand readiness (rdy_q). An
// entry requests issue when it is both valid and ready. One requester is
// chosen round-robin starting at ptr_q and is presented on issue_addr, which
// feeds a 4:1 operand/instruction mux directly. A presented grant that is
// not accepted is locked until the downstream unit takes it.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   flush        clear all entries and any held grant (mispredict recovery)
//   alloc_en     write one entry this cycle
//   alloc_slot   index of the entry being written
//   alloc_rdy    operands already available at allocation
//   wakeup       per-entry operand-ready pulse
//   issue_ready  downstream accepts the presented entry this cycle
//   issue_valid  an entry is presented for issue
//   issue_addr   index of the presented entry
//   free         bit i high when entry i is unoccupied
//   count        number of occupied entries (0..4)
//   alloc_err    sticky: an allocation targeted an occupied entry
module issue_select4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       alloc_en,
    input  logic [1:0] alloc_slot,
    input  logic       alloc_rdy,
    input  logic [3:0] wakeup,
    input  logic       issue_ready,
    output logic       issue_valid,
    output logic [1:0] issue_addr,
    output logic [3:0] free,
    output logic [2:0] count,
    output logic       alloc_err
);

    logic [3:0] valid_q;
    logic [3:0] rdy_q;
    logic [1:0] ptr_q;
    logic       lock_q;
    logic [1:0] lock_addr_q;
    logic       alloc_err_q;

    logic [3:0] request;
    logic       rr_valid;
    logic [1:0] rr_addr;
    logic [1:0] idx;

    logic       fire;
    logic       alloc_ok;
    logic [3:0] valid_n;
    logic [3:0] rdy_n;

    // Round-robin pick from registered state only. Scanning offsets from the
    // far end down lets the smallest offset from ptr_q win.
    always_comb begin
        request  = valid_q & rdy_q;
        rr_valid = 1'b0;
        rr_addr  = 2'd0;
        idx      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + k[1:0];
            if (request[idx]) begin
                rr_valid = 1'b1;
                rr_addr  = idx;
            end
        end
        // A held grant keeps the mux address stable until it is accepted;
        // the locked entry cannot leave except by issue or flush, both of
        // which also drop the lock.
        if (lock_q) begin
            issue_valid = request[lock_addr_q];
            issue_addr  = lock_addr_q;
        end else begin
            issue_valid = rr_valid;
            issue_addr  = rr_addr;
        end
    end

    always_comb begin
        free  = ~valid_q;
        count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            count = count + {2'b00, valid_q[i]};
        end
    end

    assign alloc_err = alloc_err_q;

    // Next entry state. Occupancy is judged on valid_q before the edge, so an
    // allocation aimed at the entry issuing this cycle is refused. Wakeups
    // only land on entries that are occupied or being allocated now.
    always_comb begin
        fire     = issue_valid & issue_ready;
        alloc_ok = alloc_en & ~valid_q[alloc_slot];
        valid_n  = valid_q;
        rdy_n    = rdy_q | (wakeup & valid_q);
        if (fire) begin
            valid_n[issue_addr] = 1'b0;
            rdy_n[issue_addr]   = 1'b0;
        end
        if (alloc_ok) begin
            valid_n[alloc_slot] = 1'b1;
            rdy_n[alloc_slot]   = alloc_rdy | wakeup[alloc_slot];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 4'b0000;
            rdy_q       <= 4'b0000;
            ptr_q       <= 2'd0;
            lock_q      <= 1'b0;
            alloc_err_q <= 1'b0;
        end else if (flush) begin
            // ptr_q and alloc_err_q are deliberately preserved across a flush.
            valid_q <= 4'b0000;
            rdy_q   <= 4'b0000;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= valid_n;
            rdy_q   <= rdy_n;
            if (fire) begin
                ptr_q <= issue_addr + 2'd1;
            end
            lock_q <= issue_valid & ~issue_ready;
            if (alloc_en & valid_q[alloc_slot]) begin
                alloc_err_q <= 1'b1;
            end
        end
    end

    // lock_addr_q is only meaningful while lock_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (issue_valid & ~issue_ready) begin
            lock_addr_q <= issue_addr;
        end
    end

endmodule

// File: tb/tb_issue_select4.sv
module tb_issue_select4;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       alloc_en;
    logic [1:0] alloc_slot;
    logic       alloc_rdy;
    logic [3:0] wakeup;
    logic       issue_ready;
    logic       issue_valid;
    logic [1:0] issue_addr;
    logic [3:0] free;
    logic [2:0] count;
    logic       alloc_err;

    int total;
    int bad;

    // Reference model: a table of four entries, each occupied/ready.
    bit m_occ [4];
    bit m_rdy [4];
    int m_ptr;
    bit m_lock;
    int m_lock_addr;
    bit m_err;

    issue_select4 dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .alloc_en   (alloc_en),
        .alloc_slot (alloc_slot),
        .alloc_rdy  (alloc_rdy),
        .wakeup     (wakeup),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .free       (free),
        .count      (count),
        .alloc_err  (alloc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which entry the queue offers: the held one if a grant is pending,
    // otherwise the first ready occupant found walking forward from ptr.
    function automatic void model_sel(output bit v, output int a);
        v = 0;
        a = 0;
        if (m_lock) begin
            v = 1;
            a = m_lock_addr;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            int e;
            e = (m_ptr + k) % 4;
            if (m_occ[e] && m_rdy[e]) begin
                v = 1;
                a = e;
                return;
            end
        end
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += m_occ[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [3:0] model_free();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = !m_occ[i];
        return f;
    endfunction

    function automatic void model_edge();
        bit v;
        int a;
        bit was [4];
        bit fire;
        int s;
        model_sel(v, a);
        for (int i = 0; i < 4; i++) was[i] = m_occ[i];
        if (reset) begin
            for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_rdy[i] = 0; end
            m_ptr  = 0;
            m_lock = 0;
            m_err  = 0;
            return;
        end
        if (flush) begin
            for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_rdy[i] = 0; end
            m_lock = 0;
            return;
        end
        fire = v && issue_ready;
        for (int i = 0; i < 4; i++)
            if (wakeup[i] && was[i]) m_rdy[i] = 1;
        if (fire) begin
            m_occ[a] = 0;
            m_rdy[a] = 0;
            m_ptr    = (a + 1) % 4;
            m_lock   = 0;
        end else if (v) begin
            m_lock      = 1;
            m_lock_addr = a;
        end
        if (alloc_en) begin
            s = int'(alloc_slot);
            if (was[s]) begin
                m_err = 1;
            end else begin
                m_occ[s] = 1;
                m_rdy[s] = alloc_rdy || wakeup[s];
            end
        end
    endfunction

    task automatic drive(input bit ae, input int slot, input bit ardy, input logic [3:0] wk,
                         input bit ir, input bit fl, input bit rs);
        alloc_en    = ae;
        alloc_slot  = 2'(slot);
        alloc_rdy   = ardy;
        wakeup      = wk;
        issue_ready = ir;
        flush       = fl;
        reset       = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 4'b0000, 0, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        total += 5;
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", issue_valid); end
        if (issue_addr !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", issue_addr); end
        if (free !== 4'b1111) begin bad++; $display("FAIL reset_free got=%b want=1111", free); end
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        if (alloc_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", alloc_err); end
    endtask

    task automatic test_single_issue();
        apply_reset();
        drive(1, 2, 1, 4'b0000, 1, 0, 0);
        tick();
        drive(0, 0, 0, 4'b0000, 1, 0, 0);
        total += 2;
        if (issue_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", issue_valid); end
        if (issue_addr !== 2'd2) begin bad++; $display("FAIL single_addr got=%0d want=2", issue_addr); end
        tick();
        total += 3;
        if (free !== 4'b1111) begin bad++; $display("FAIL single_free got=%b want=1111", free); end
        if (dut.ptr_q !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d want=3", dut.ptr_q); end
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%0b want=0", issue_valid); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            drive(1, s, 1, 4'b0000, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 4'b0000, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            total += 3;
            if (issue_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0b want=1", k, issue_valid); end
            if (issue_addr !== 2'(k)) begin bad++; $display("FAIL rr_addr[%0d] got=%0d want=%0d", k, issue_addr, k); end
            if (count !== 3'(4 - k)) begin bad++; $display("FAIL rr_count[%0d] got=%0d want=%0d", k, count, 4 - k); end
            tick();
        end
        total += 2;
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL rr_end_valid got=%0b want=0", issue_valid); end
        if (count !== 3'd0) begin bad++; $display("FAIL rr_end_count got=%0d want=0", count); end
    endtask

    task automatic test_lock();
        apply_reset();
        drive(1, 3, 1, 4'b0000, 0, 0, 0);
        tick();
        drive(1, 0, 0, 4'b0000, 0, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, (c == 0) ? 4'b0001 : 4'b0000, 0, 0, 0);
            total += 1;
            if (issue_addr !== 2'd3) begin bad++; $display("FAIL lock_hold[%0d] got=%0d want=3", c, issue_addr); end
            tick();
        end
        drive(0, 0, 0, 4'b0000, 1, 0, 0);
        total += 2;
        if (issue_valid !== 1'b1 || issue_addr !== 2'd3) begin
            bad++; $display("FAIL lock_accept got=%0b/%0d want=1/3", issue_valid, issue_addr);
        end
        if (count !== 3'd2) begin bad++; $display("FAIL lock_count got=%0d want=2", count); end
        tick();
        total += 1;
        if (issue_valid !== 1'b1 || issue_addr !== 2'd0) begin
            bad++; $display("FAIL lock_next got=%0b/%0d want=1/0", issue_valid, issue_addr);
        end
        tick();
    endtask

    task automatic test_double_alloc();
        apply_reset();
        drive(1, 1, 0, 4'b0000, 0, 0, 0);
        tick();
        drive(1, 1, 1, 4'b0000, 0, 0, 0);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0, 0);
        total += 3;
        if (alloc_err !== 1'b1) begin bad++; $display("FAIL dbl_err got=%0b want=1", alloc_err); end
        if (count !== 3'd1) begin bad++; $display("FAIL dbl_count got=%0d want=1", count); end
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL dbl_unchanged got=%0b want=0", issue_valid); end
        tick();
        tick();
        total += 1;
        if (alloc_err !== 1'b1) begin bad++; $display("FAIL dbl_sticky got=%0b want=1", alloc_err); end
        apply_reset();
        total += 1;
        if (alloc_err !== 1'b0) begin bad++; $display("FAIL dbl_cleared got=%0b want=0", alloc_err); end
    endtask

    task automatic test_wakeup();
        apply_reset();
        drive(1, 0, 0, 4'b0000, 0, 0, 0);
        tick();
        drive(0, 0, 0, 4'b0001, 0, 0, 0);
        total += 1;
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL wk_before got=%0b want=0", issue_valid); end
        tick();
        drive(0, 0, 0, 4'b1000, 0, 0, 0);
        total += 1;
        if (issue_valid !== 1'b1 || issue_addr !== 2'd0) begin
            bad++; $display("FAIL wk_after got=%0b/%0d want=1/0", issue_valid, issue_addr);
        end
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0, 0);
        total += 2;
        if (free !== 4'b1110) begin bad++; $display("FAIL wk_free got=%b want=1110", free); end
        if (count !== 3'd1) begin bad++; $display("FAIL wk_count got=%0d want=1", count); end
        // A later alloc into slot 3 must not inherit the dropped wakeup.
        drive(1, 3, 0, 4'b0000, 1, 0, 0);
        tick();
        drive(0, 0, 0, 4'b0000, 1, 0, 0);
        tick();
        total += 1;
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL wk_dropped got=%0b want=0", issue_valid); end
    endtask

    task automatic test_flush_and_reset();
        apply_reset();
        // Move ptr to 2 so preservation across flush is observable.
        drive(1, 1, 1, 4'b0000, 1, 0, 0);
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1, s, 1, 4'b0000, 0, 0, 0);
            tick();
        end
        drive(1, 3, 1, 4'b0000, 1, 1, 0);
        total += 1;
        if (count !== 3'd3) begin bad++; $display("FAIL fl_pre_count got=%0d want=3", count); end
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0, 0);
        total += 4;
        if (count !== 3'd0) begin bad++; $display("FAIL fl_count got=%0d want=0", count); end
        if (free !== 4'b1111) begin bad++; $display("FAIL fl_free got=%b want=1111", free); end
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0b want=0", issue_valid); end
        if (dut.ptr_q !== 2'd2) begin bad++; $display("FAIL fl_ptr got=%0d want=2", dut.ptr_q); end
        for (int s = 0; s < 3; s++) begin
            drive(1, s, 1, 4'b0000, 0, 0, 0);
            tick();
        end
        drive(1, 3, 1, 4'b1111, 1, 1, 1);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0, 0);
        total += 5;
        if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", issue_valid); end
        if (issue_addr !== 2'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", issue_addr); end
        if (free !== 4'b1111) begin bad++; $display("FAIL rst_free got=%b want=1111", free); end
        if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        if (dut.ptr_q !== 2'd0) begin bad++; $display("FAIL rst_ptr got=%0d want=0", dut.ptr_q); end
    endtask

    task automatic test_random();
        bit v;
        int a;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 2) == 0,
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 150) == 0);
            tick();
            model_sel(v, a);
            total += 5;
            if (issue_valid !== v) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, issue_valid, v); end
            if (issue_addr !== 2'(a)) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d want=%0d", c, issue_addr, a); end
            if (free !== model_free()) begin bad++; $display("FAIL rnd_free c=%0d got=%b want=%b", c, free, model_free()); end
            if (count !== 3'(model_count())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, model_count()); end
            if (alloc_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, alloc_err, m_err); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(0, 0, 0, 4'b0000, 0, 0, 1);
        test_reset();
        test_single_issue();
        test_round_robin();
        test_lock();
        test_double_alloc();
        test_wakeup();
        test_flush_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
